imem_loader: RTL
================

Name: imem_loader

Overview:
- Upstream feeder of the fetch stage's instruction-memory write port.
- Assembles serial bytes from the UART receiver into 32-bit instruction words and writes each word into instruction memory at consecutive word addresses.
- Stops on a halt word, then releases the pipeline clock enable.
- Holds the pipeline frozen for the whole load, and on any load error.

Parameters:
- ADDR_W, 8: instruction-memory byte-address width; memory holds 2^ADDR_W bytes.
- HALT_WORD, 32'hFFFFFFFF: end-of-program marker; it is written to memory before load completes.
- TIMEOUT_CYCLES, 100000: maximum idle cycles between bytes of a partially received word; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse; begins a new program load
- i_rx_valid  in  1  single-cycle strobe; i_rx_data holds a received byte
- i_rx_data  in  8  received byte, most-significant byte of each word first
- o_write_en  out  1  instruction-memory write strobe, one cycle per word
- o_data  out  32  word to write; valid while o_write_en=1
- o_addr_wr  out  32  byte address of write, word-aligned; bits [31:ADDR_W] are 0
- o_clk_en  out  1  pipeline clock enable; 1 only in DONE
- o_busy  out  1  1 in RECV and WRITE
- o_done  out  1  1 in DONE
- o_error  out  1  1 in ERROR
- o_word_count  out  ADDR_W-1  number of words written in the current/last load, halt word included

Behaviour:
- Reset (i_reset=0, asynchronous) forces all outputs to 0 and the state to IDLE. Internal word, byte counter, address and timeout counter are cleared. A reset mid-load aborts with no further writes.
- States: IDLE, RECV, WRITE, DONE, ERROR. All outputs are registered.
- IDLE:
  - All outputs are 0.
  - i_start moves to RECV and clears address, byte count, word count and timeout counter.
  - i_rx_valid is ignored.
- RECV:
  - On i_rx_valid: word <= {word[23:0], i_rx_data}; byte_cnt++.
  - On acceptance of the 4th byte: next cycle enters WRITE with o_write_en=1, o_data=assembled word, o_addr_wr=current address; byte_cnt returns to 0.
- WRITE (exactly one cycle):
  - o_word_count increments.
  - If o_data==HALT_WORD, go to DONE.
  - Else if the address just written is 2^ADDR_W-4, go to ERROR (memory overflow, no wrap).
  - Else address += 4 and return to RECV.
- Byte during WRITE: an i_rx_valid arriving in the WRITE cycle is accepted as byte 0 of the next word. No byte is ever dropped.
- Timeout:
  - In RECV with byte_cnt≠0, the idle counter increments each cycle without i_rx_valid and clears on any accepted byte.
  - Reaching TIMEOUT_CYCLES moves to ERROR. With byte_cnt=0 the counter is held at 0.
- Ignored inputs: i_start is ignored in RECV and WRITE.
- DONE: o_clk_en=1 and o_done=1; bytes are ignored. i_start moves to RECV as in IDLE; o_clk_en drops the next cycle.
- ERROR: o_error=1 and o_clk_en=0; bytes are ignored. i_start restarts as from IDLE.
- Latency: the write strobe appears 1 cycle after the 4th byte's i_rx_valid cycle.
- Simultaneous events: i_start together with i_rx_valid in IDLE/DONE/ERROR discards the byte.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3, ERROR=4, 3-bit)
  - default HALT_WORD constant
  - WORD_BYTES=4
- Natural sub-module: word_assembler, containing the shift register, byte counter and "word complete" pulse.
- FSM, address, timeout counter and outputs stay in imem_loader.

Test Plan:
- Reset mid-load: after 2 bytes of a word, drive i_reset=0 -> all outputs 0 immediately; after release no o_write_en occurs, and the next i_start plus 4 bytes writes address 0.
- Two-word program: i_start; bytes 20 08 00 05, FF FF FF FF -> writes 0x20080005 at addr 0 and 0xFFFFFFFF at addr 4; o_done=1, o_clk_en=1, o_word_count=2.
- Back-to-back bytes: i_rx_valid every cycle including the WRITE cycle, for 3 words then halt -> no byte lost; data at 0,4,8 match exactly; halt written at 12.
- Overflow: ADDR_W=4, feed 4 non-halt words -> writes at 0,4,8,12, then o_error=1, o_clk_en=0, no write beyond 12.
- Timeout: TIMEOUT_CYCLES=10, send 1 byte then idle -> o_error=1 on the 10th idle cycle. Idling with byte_cnt=0 for 50 cycles -> no error.
- Restart from DONE: i_start in DONE -> o_clk_en=0 the next cycle; a new load begins at addr 0 with o_word_count cleared.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : shared state encoding and constants for the program loader
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned c_BYTE_CNT_W      = $clog2(WORD_BYTES);

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ============================================================================
// imem_loader_word_assembler : MSB-first byte-to-word shift register
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic [7:0]              i_byte,
  output logic [31:0]             o_word_next,
  output logic [c_BYTE_CNT_W-1:0] o_byte_cnt,
  output logic                    o_complete
);

  // Only the three most recent bytes need storing; the fourth arrives live.
  logic [23:0]             r_word;
  logic [c_BYTE_CNT_W-1:0] r_byte_cnt;

  assign o_word_next = {r_word, i_byte};
  assign o_byte_cnt  = r_byte_cnt;
  assign o_complete  = i_accept && (r_byte_cnt == c_BYTE_CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_word     <= o_word_next[23:0];
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : loads a UART byte stream into instruction memory, then
//               releases the pipeline clock enable. Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_write_en,
  output logic [31:0]       o_data,
  output logic [31:0]       o_addr_wr,
  output logic              o_clk_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-2:0] o_word_count
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] c_ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic              c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]       c_TO_LAST    = (TIMEOUT_CYCLES == 0) ? 32'd0
                                                : 32'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [31:0]             r_timeout;

  logic                    w_idle_like;
  logic                    w_accept;
  logic                    w_clear;
  logic [31:0]             w_word_next;
  logic [c_BYTE_CNT_W-1:0] w_byte_cnt;
  logic                    w_complete;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_clear     = w_idle_like && i_start;
  // The WRITE cycle also accepts bytes so a continuous stream loses nothing.
  assign w_accept    = i_rx_valid && ((r_state == ST_RECV) || (r_state == ST_WRITE));

  imem_loader_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst_n     (i_reset),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_byte      (i_rx_data),
    .o_word_next (w_word_next),
    .o_byte_cnt  (w_byte_cnt),
    .o_complete  (w_complete)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_timeout    <= '0;
      o_write_en   <= 1'b0;
      o_data       <= '0;
      o_addr_wr    <= '0;
      o_clk_en     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_write_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            r_state      <= ST_RECV;
            r_addr       <= '0;
            r_timeout    <= '0;
            o_word_count <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_clk_en     <= 1'b0;
            o_error      <= 1'b0;
          end
        end
        ST_RECV: begin
          if (w_complete) begin
            r_state    <= ST_WRITE;
            r_timeout  <= '0;
            o_write_en <= 1'b1;
            o_data     <= w_word_next;
            o_addr_wr  <= {{(32-ADDR_W){1'b0}}, r_addr};
          end else if (i_rx_valid || (w_byte_cnt == '0)) begin
            r_timeout <= '0;
          end else if (c_TIMEOUT_EN && (r_timeout == c_TO_LAST)) begin
            r_state <= ST_ERROR;
            o_busy  <= 1'b0;
            o_error <= 1'b1;
          end else begin
            r_timeout <= r_timeout + 32'd1;
          end
        end
        ST_WRITE: begin
          o_word_count <= o_word_count + 1'b1;
          r_timeout    <= '0;
          if (o_data == HALT_WORD) begin
            r_state  <= ST_DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_clk_en <= 1'b1;
          end else if (r_addr == c_LAST_ADDR) begin
            // Memory full without a halt word: refuse to wrap onto address 0.
            r_state <= ST_ERROR;
            o_busy  <= 1'b0;
            o_error <= 1'b1;
          end else begin
            r_state <= ST_RECV;
            r_addr  <= r_addr + c_ADDR_STEP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
